// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use/branch/HI-LO stalls and HI/LO busy tracking.
// Optional stall performance counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic        BranchD,
  input  logic        MulDivD,
  input  logic        HiLoReadD,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        MemtoRegM,
  input  logic        MulDivStartE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushE,
  output logic        MulDivBusy,
  output logic [31:0] StallCount
);

  // state | meaning
  // IDLE  | HI/LO unit free, no mult/div in flight
  // BUSY  | mult/div occupying HI/LO; counter holds remaining cycles minus one
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [5:0] LOAD = 6'(MULDIV_CYCLES - 1);

  state_t     state;
  logic [5:0] cnt;
  logic       lwstall, brstall, mdstall, stall;

  always_comb begin
    ForwardAE = 2'd0;
    if (RegWriteM && WriteRegM != 5'd0 && WriteRegM == RsE)      ForwardAE = 2'd2;
    else if (RegWriteW && WriteRegW != 5'd0 && WriteRegW == RsE) ForwardAE = 2'd1;
  end

  always_comb begin
    ForwardBE = 2'd0;
    if (RegWriteM && WriteRegM != 5'd0 && WriteRegM == RtE)      ForwardBE = 2'd2;
    else if (RegWriteW && WriteRegW != 5'd0 && WriteRegW == RtE) ForwardBE = 2'd1;
  end

  assign ForwardAD = (RsD != 5'd0) && RegWriteM && (WriteRegM == RsD);
  assign ForwardBD = (RtD != 5'd0) && RegWriteM && (WriteRegM == RtD);

  assign lwstall = MemtoRegE && (RtE != 5'd0) && (RtE == RsD || RtE == RtD);

  // A branch resolves in decode, so it must wait for any producer still in E or a load in M.
  assign brstall = BranchD &&
    (((RsD != 5'd0) && ((RegWriteE && WriteRegE == RsD) || (MemtoRegM && WriteRegM == RsD))) ||
     ((RtD != 5'd0) && ((RegWriteE && WriteRegE == RtD) || (MemtoRegM && WriteRegM == RtD))));

  assign mdstall = (state == BUSY) && (MulDivD || HiLoReadD);
  assign stall   = lwstall || brstall || mdstall;

  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 6'd0;
      MulDivBusy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MulDivStartE) begin
            state      <= BUSY;
            cnt        <= LOAD;
            MulDivBusy <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt == 6'd0) begin
            state      <= IDLE;
            MulDivBusy <= 1'b0;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= 6'd0;
          MulDivBusy <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     stall_cnt <= 32'd0;
    else if (stall) stall_cnt <= stall_cnt + 32'd1;
  end

  assign StallCount = stall_cnt;
`else
  assign StallCount = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl against a rule-level reference model, plus pinned literal cases.
module tb_hazard_ctrl;
  localparam int MC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  RsD = 0, RtD = 0, RsE = 0, RtE = 0;
  logic [4:0]  WriteRegE = 0, WriteRegM = 0, WriteRegW = 0;
  logic        BranchD = 0, MulDivD = 0, HiLoReadD = 0;
  logic        RegWriteE = 0, RegWriteM = 0, RegWriteW = 0;
  logic        MemtoRegE = 0, MemtoRegM = 0, MulDivStartE = 0;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        ForwardAD, ForwardBD, StallF, StallD, FlushE, MulDivBusy;
  logic [31:0] StallCount;

  int tests = 0;
  int errors = 0;

  int          busy_left = 0;
  logic [31:0] model_cnt = 32'd0;

  hazard_ctrl #(.MULDIV_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n),
    .RsD(RsD), .RtD(RtD), .BranchD(BranchD), .MulDivD(MulDivD), .HiLoReadD(HiLoReadD),
    .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MulDivStartE(MulDivStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .MulDivBusy(MulDivBusy), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_e(input logic [4:0] src);
    if (RegWriteM && WriteRegM != 0 && WriteRegM == src) return 2'd2;
    if (RegWriteW && WriteRegW != 0 && WriteRegW == src) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic fwd_d(input logic [4:0] src);
    return src != 0 && RegWriteM && WriteRegM == src;
  endfunction

  function automatic logic br_dep(input logic [4:0] x);
    return x != 0 && ((RegWriteE && WriteRegE == x) || (MemtoRegM && WriteRegM == x));
  endfunction

  function automatic logic exp_stall();
    logic lw, br, md;
    lw = MemtoRegE && RtE != 0 && (RtE == RsD || RtE == RtD);
    br = BranchD && (br_dep(RsD) || br_dep(RtD));
    md = (busy_left > 0) && (MulDivD || HiLoReadD);
    return lw || br || md;
  endfunction

  // Reference: busy_left counts the remaining occupied cycles of the HI/LO unit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_left = 0;
      model_cnt = 32'd0;
    end else begin
`ifdef HAZARD_PERF_CNT_EN
      if (exp_stall()) model_cnt = model_cnt + 32'd1;
`endif
      if (busy_left > 0) busy_left = busy_left - 1;
      else if (MulDivStartE) busy_left = MC;
    end
  end

  always @(negedge clk) begin
    logic s;
    s = exp_stall();
    check("ForwardAE", 32'(ForwardAE), 32'(fwd_e(RsE)));
    check("ForwardBE", 32'(ForwardBE), 32'(fwd_e(RtE)));
    check("ForwardAD", 32'(ForwardAD), 32'(fwd_d(RsD)));
    check("ForwardBD", 32'(ForwardBD), 32'(fwd_d(RtD)));
    check("StallF", 32'(StallF), 32'(s));
    check("StallD", 32'(StallD), 32'(s));
    check("FlushE", 32'(FlushE), 32'(s));
    check("MulDivBusy", 32'(MulDivBusy), 32'(busy_left > 0));
    check("StallCount", StallCount, model_cnt);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    BranchD = 0; MulDivD = 0; HiLoReadD = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; MulDivStartE = 0;
  endtask

  initial begin
    sample();
    check("reset_busy", 32'(MulDivBusy), 32'd0);
    check("reset_count", StallCount, 32'd0);
    step();
    rst_n = 1'b1;

    // forwarding priority
    step(); idle_inputs();
    RsE = 5; RegWriteM = 1; WriteRegM = 5; RegWriteW = 1; WriteRegW = 5;
    sample(); check("lit_fwd_m", 32'(ForwardAE), 32'd2);
    step(); RegWriteM = 0;
    sample(); check("lit_fwd_w", 32'(ForwardAE), 32'd1);
    step(); RsE = 0; RegWriteM = 1; WriteRegM = 0; WriteRegW = 0;
    sample(); check("lit_fwd_r0", 32'(ForwardAE), 32'd0);

    // load-use
    step(); idle_inputs(); MemtoRegE = 1; RtE = 8; RsD = 8;
    sample(); check("lit_lw_stall", {29'd0, StallF, StallD, FlushE}, 32'd7);
    step(); RsD = 0; RtD = 8; RtE = 0;
    sample(); check("lit_lw_r0", {29'd0, StallF, StallD, FlushE}, 32'd0);

    // branch dependency then forward from M
    step(); idle_inputs(); BranchD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3;
    sample(); check("lit_br_stall", 32'(StallD), 32'd1);
    step(); RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 3; MemtoRegM = 0;
    sample(); check("lit_br_nostall", 32'(StallD), 32'd0);
    check("lit_br_fwd", 32'(ForwardAD), 32'd1);

    // HI/LO busy window with an ignored restart
    step(); idle_inputs(); MulDivStartE = 1;
    sample(); check("lit_md_c0", {30'd0, MulDivBusy, StallD}, 32'd0);
    step(); MulDivStartE = 0;
    sample(); check("lit_md_c1", {30'd0, MulDivBusy, StallD}, 32'd2);
    step(); HiLoReadD = 1; MulDivStartE = 1;
    sample(); check("lit_md_c2", {30'd0, MulDivBusy, StallD}, 32'd3);
    step(); MulDivStartE = 0;
    sample(); check("lit_md_c3", {30'd0, MulDivBusy, StallD}, 32'd3);
    step();
    sample(); check("lit_md_c4", {30'd0, MulDivBusy, StallD}, 32'd3);
    step();
    sample(); check("lit_md_c5", {30'd0, MulDivBusy, StallD}, 32'd0);

    // reset in the middle of BUSY
    step(); idle_inputs(); MulDivStartE = 1;
    step(); MulDivStartE = 0;
    step(); rst_n = 1'b0;
    sample(); check("lit_rst_busy", 32'(MulDivBusy), 32'd0);
    #1 rst_n = 1'b1;
    step(); HiLoReadD = 1;
    sample(); check("lit_rst_nostall", 32'(StallD), 32'd0);
    step();
    sample(); check("lit_rst_nostall2", {30'd0, MulDivBusy, StallD}, 32'd0);

    // 3 load-use stalls plus a 4-cycle mdstall
    step(); idle_inputs(); rst_n = 1'b0;
    sample(); #1 rst_n = 1'b1;
    step(); MemtoRegE = 1; RtE = 8; RsD = 8;
    step(); step();
    step(); idle_inputs(); MulDivStartE = 1;
    step(); MulDivStartE = 0; MulDivD = 1;
    step(); step(); step();
    step();
    sample();
`ifdef HAZARD_PERF_CNT_EN
    check("lit_stall_count", StallCount, 32'd7);
`else
    check("lit_stall_count", StallCount, 32'd0);
`endif
    step(); idle_inputs();

    for (int i = 0; i < 3000; i++) begin
      step();
      RsD = 5'($urandom_range(0, 7)); RtD = 5'($urandom_range(0, 7));
      RsE = 5'($urandom_range(0, 7)); RtE = 5'($urandom_range(0, 7));
      WriteRegE = 5'($urandom_range(0, 7));
      WriteRegM = 5'($urandom_range(0, 7));
      WriteRegW = 5'($urandom_range(0, 7));
      BranchD = 1'($urandom_range(0, 1));
      RegWriteE = 1'($urandom_range(0, 1));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      MemtoRegE = ($urandom_range(0, 3) == 0);
      MemtoRegM = ($urandom_range(0, 3) == 0);
      MulDivD = ($urandom_range(0, 3) == 0);
      HiLoReadD = ($urandom_range(0, 3) == 0);
      MulDivStartE = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        sample();
        #1 rst_n = 1'b1;
      end
    end

    step();
    sample();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
